// File: rtl/riscv_ctrl_pkg.sv
// Shared control-path definitions for the ID-stage redirect/flush logic
// and the pipeline registers it drives.
package riscv_ctrl_pkg;

  localparam int XLEN = 32;

  // Pipeline registers load this (addi x0, x0, 0) when they are flushed.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Wide enough for the largest supported KILL_SLOTS value (7).
  localparam int SLOT_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } rf_state_e;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/redirect_flush_control_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Intended for reuse as a generic performance/event counter.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/redirect_flush_control.sv
// Kills wrong-path instructions on a taken jump/branch resolved in ID:
// redirects fetch once, then holds IF/ID flushed for KILL_SLOTS more cycles.
module redirect_flush_control
  import riscv_ctrl_pkg::*;
#(
  parameter int KILL_SLOTS = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jmp_req_ID,
  input  logic [XLEN-1:0]  jmp_pc_ID,
  input  logic             ena_ifid,
  output logic [XLEN-1:0]  new_PC,
  output logic             ena_new_PC,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             misaligned,
  output logic             busy,
  output logic [CNT_W-1:0] redirect_count
);

  localparam logic [SLOT_W-1:0] KILL_INIT = SLOT_W'(KILL_SLOTS);

  rf_state_e         state_q, state_d;
  logic [SLOT_W-1:0] remaining_q, remaining_d;
  logic [XLEN-1:0]   new_pc_q, new_pc_d;
  logic              ena_new_pc_q, ena_new_pc_d;
  logic              flush_ifid_q, flush_ifid_d;
  logic              flush_idex_q, flush_idex_d;
  logic              misaligned_q, misaligned_d;
  logic              busy_q, busy_d;

  logic accept;
  logic redirect_go;

  // A stalled ID (ena_ifid=0) re-presents the same request later, so
  // acceptance simply waits for the enable.
  assign accept      = (state_q == IDLE) && jmp_req_ID && ena_ifid;
  assign redirect_go = accept && is_word_aligned(jmp_pc_ID);

  // NOTE: every variable written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    new_pc_d     = new_pc_q;
    ena_new_pc_d = 1'b0;
    flush_ifid_d = 1'b0;
    flush_idex_d = 1'b0;
    misaligned_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (redirect_go) begin
          state_d      = REDIRECT;
          new_pc_d     = jmp_pc_ID;
          ena_new_pc_d = 1'b1;
          flush_ifid_d = 1'b1;
          flush_idex_d = 1'b1;
        end else if (accept) begin
          misaligned_d = 1'b1;
        end
      end
      REDIRECT: begin
        state_d      = FLUSH;
        remaining_d  = KILL_INIT;
        flush_ifid_d = 1'b1;
      end
      FLUSH: begin
        // Requests and stalls seen here belong to wrong-path instructions.
        if (remaining_q <= SLOT_W'(1)) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else begin
          remaining_d  = remaining_q - SLOT_W'(1);
          flush_ifid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      new_pc_q     <= '0;
      ena_new_pc_q <= 1'b0;
      flush_ifid_q <= 1'b0;
      flush_idex_q <= 1'b0;
      misaligned_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      new_pc_q     <= new_pc_d;
      ena_new_pc_q <= ena_new_pc_d;
      flush_ifid_q <= flush_ifid_d;
      flush_idex_q <= flush_idex_d;
      misaligned_q <= misaligned_d;
      busy_q       <= busy_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_redirect_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (redirect_go),
    .count (redirect_count)
  );

  assign new_PC     = new_pc_q;
  assign ena_new_PC = ena_new_pc_q;
  assign flush_ifid = flush_ifid_q;
  assign flush_idex = flush_idex_q;
  assign misaligned = misaligned_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_redirect_flush_control.sv
// Directed bench for redirect_flush_control: one instance with KILL_SLOTS=1,
// one with KILL_SLOTS=4 / CNT_W=4; redirect events are checked off a queue.
module tb_redirect_flush_control;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst4;
  logic        jmp_req;
  logic [31:0] jmp_pc;
  logic        ena_ifid;

  logic [31:0] new_pc1, new_pc4;
  logic        ena1, ena4, fi1, fi4, fx1, fx4, mis1, mis4, busy1, busy4;
  logic [15:0] cnt1;
  logic [3:0]  cnt4;

  redirect_flush_control #(.KILL_SLOTS(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst1), .jmp_req_ID(jmp_req), .jmp_pc_ID(jmp_pc),
    .ena_ifid(ena_ifid), .new_PC(new_pc1), .ena_new_PC(ena1),
    .flush_ifid(fi1), .flush_idex(fx1), .misaligned(mis1),
    .busy(busy1), .redirect_count(cnt1)
  );

  redirect_flush_control #(.KILL_SLOTS(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .jmp_req_ID(jmp_req), .jmp_pc_ID(jmp_pc),
    .ena_ifid(ena_ifid), .new_PC(new_pc4), .ena_new_PC(ena4),
    .flush_ifid(fi4), .flush_idex(fx4), .misaligned(mis4),
    .busy(busy4), .redirect_count(cnt4)
  );

  typedef struct {
    bit          is_mis;
    logic [31:0] pc;
    int          count;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_redirect(input int which, input logic [31:0] pc, input int count);
    exp_t e;
    e = '{is_mis: 1'b0, pc: pc, count: count};
    if (which == 1) q1.push_back(e);
    else            q4.push_back(e);
  endtask

  task automatic push_misaligned(input int which, input int count);
    exp_t e;
    e = '{is_mis: 1'b1, pc: 32'h0, count: count};
    if (which == 1) q1.push_back(e);
    else            q4.push_back(e);
  endtask

  // Compares one observed strobe/pulse against the oldest expected event.
  task automatic score(input string tag, input bit have, input exp_t e,
                       input logic ena, input logic mis, input logic fi,
                       input logic fx, input logic [31:0] pc, input int cnt);
    if (!have) begin
      check({tag, " unexpected event"}, {30'b0, ena, mis}, 32'h0);
    end else if (e.is_mis) begin
      check({tag, " mis flag"},      mis, 1'b1);
      check({tag, " mis no strobe"}, ena, 1'b0);
      check({tag, " mis no flush"},  {30'b0, fi, fx}, 32'h0);
      check({tag, " mis count"},     cnt, e.count);
    end else begin
      check({tag, " redirect pc"},    pc,  e.pc);
      check({tag, " redirect ena"},   ena, 1'b1);
      check({tag, " redirect fifid"}, fi,  1'b1);
      check({tag, " redirect fidex"}, fx,  1'b1);
      check({tag, " redirect count"}, cnt, e.count);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    bit   have;
    if (ena1 || mis1) begin
      have = (q1.size() != 0);
      e    = '{is_mis: 1'b0, pc: 32'h0, count: 0};
      if (have) e = q1.pop_front();
      score("dut1", have, e, ena1, mis1, fi1, fx1, new_pc1, int'(cnt1));
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    bit   have;
    if (ena4 || mis4) begin
      have = (q4.size() != 0);
      e    = '{is_mis: 1'b0, pc: 32'h0, count: 0};
      if (have) e = q4.pop_front();
      score("dut4", have, e, ena4, mis4, fi4, fx4, new_pc4, int'(cnt4));
    end
  end

  initial begin
    rst1 = 1'b1; rst4 = 1'b1;
    jmp_req = 1'b0; jmp_pc = 32'h0; ena_ifid = 1'b1;
    tick(); tick();

    check("d1 reset new_pc", new_pc1, 32'h0);
    check("d1 reset ena",    ena1, 1'b0);
    check("d1 reset flush",  {30'b0, fi1, fx1}, 32'h0);
    check("d1 reset mis",    mis1, 1'b0);
    check("d1 reset busy",   busy1, 1'b0);
    check("d1 reset count",  cnt1, 32'h0);
    rst1 = 1'b0;
    tick();
    check("d1 post-reset no strobe", ena1, 1'b0);

    // Basic aligned redirect, KILL_SLOTS=1.
    push_redirect(1, 32'h100, 1);
    jmp_req = 1'b1; jmp_pc = 32'h100; tick(); jmp_req = 1'b0;
    check("s1 c1 busy", busy1, 1'b1);
    tick();
    check("s1 c2 flush_ifid", fi1, 1'b1);
    check("s1 c2 flush_idex", fx1, 1'b0);
    check("s1 c2 ena",        ena1, 1'b0);
    check("s1 c2 busy",       busy1, 1'b1);
    tick();
    check("s1 c3 flush_ifid", fi1, 1'b0);
    check("s1 c3 busy",       busy1, 1'b0);
    check("s1 count",         cnt1, 32'd1);

    // Request held while ID is stalled.
    jmp_req = 1'b1; jmp_pc = 32'h200; ena_ifid = 1'b0;
    repeat (3) begin
      tick();
      check("s2 stalled ena",  ena1, 1'b0);
      check("s2 stalled busy", busy1, 1'b0);
    end
    push_redirect(1, 32'h200, 2);
    ena_ifid = 1'b1; tick(); jmp_req = 1'b0;
    check("s2 strobe", ena1, 1'b1);
    tick();
    check("s2 single strobe", ena1, 1'b0);
    tick();
    check("s2 idle",     busy1, 1'b0);
    check("s2 count",    cnt1, 32'd2);
    check("s2 pc holds", new_pc1, 32'h200);

    // Misaligned target.
    push_misaligned(1, 2);
    jmp_req = 1'b1; jmp_pc = 32'h102; tick(); jmp_req = 1'b0;
    check("s3 mis",          mis1, 1'b1);
    check("s3 busy",         busy1, 1'b0);
    check("s3 pc unchanged", new_pc1, 32'h200);
    tick();
    check("s3 mis one cycle", mis1, 1'b0);
    check("s3 count",         cnt1, 32'd2);

    // Back-to-back requests: the second is wrong-path.
    push_redirect(1, 32'h300, 3);
    jmp_req = 1'b1; jmp_pc = 32'h300; tick();
    jmp_pc = 32'h400; tick(); jmp_req = 1'b0;
    check("s4 c2 pc",  new_pc1, 32'h300);
    check("s4 c2 ena", ena1, 1'b0);
    tick();
    check("s4 c3 pc",    new_pc1, 32'h300);
    check("s4 c3 busy",  busy1, 1'b0);
    check("s4 count",    cnt1, 32'd3);
    tick();
    check("s4 c4 pc", new_pc1, 32'h300);

    // Second instance: KILL_SLOTS=4, CNT_W=4.
    rst1 = 1'b1; rst4 = 1'b0;
    tick();
    check("d4 idle ena",   ena4, 1'b0);
    check("d4 idle busy",  busy4, 1'b0);
    check("d4 idle count", cnt4, 32'h0);

    // Flush width 1+4 cycles; a stall during flush does not pause it.
    push_redirect(4, 32'h500, 1);
    jmp_req = 1'b1; jmp_pc = 32'h500; tick(); jmp_req = 1'b0; ena_ifid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s5 flush_ifid held", fi4, 1'b1);
      check("s5 busy held",       busy4, 1'b1);
      check("s5 flush_idex low",  fx4, 1'b0);
    end
    tick();
    check("s5 flush_ifid end", fi4, 1'b0);
    check("s5 busy end",       busy4, 1'b0);
    ena_ifid = 1'b1;

    // Reset in the middle of FLUSH.
    push_redirect(4, 32'h600, 2);
    jmp_req = 1'b1; jmp_pc = 32'h600; tick(); jmp_req = 1'b0;
    tick(); tick();
    check("s6 in flush", fi4, 1'b1);
    rst4 = 1'b1; tick();
    check("s6 rst new_pc", new_pc4, 32'h0);
    check("s6 rst flush",  {30'b0, fi4, fx4}, 32'h0);
    check("s6 rst busy",   busy4, 1'b0);
    check("s6 rst count",  cnt4, 32'h0);
    rst4 = 1'b0; tick();
    check("s6 no strobe after rst", ena4, 1'b0);
    check("s6 no flush after rst",  fi4, 1'b0);
    check("s6 busy after rst",      busy4, 1'b0);
    push_redirect(4, 32'h100, 1);
    jmp_req = 1'b1; jmp_pc = 32'h100; tick(); jmp_req = 1'b0;
    check("s6 fresh busy", busy4, 1'b1);
    repeat (4) tick();
    check("s6 fresh last flush", fi4, 1'b1);
    tick();
    check("s6 fresh done", busy4, 1'b0);

    // Saturation of the 4-bit counter over 20 more redirects.
    for (int i = 0; i < 20; i++) begin
      push_redirect(4, 32'h1000 + 32'(i * 4), (i + 2 > 15) ? 15 : i + 2);
      jmp_req = 1'b1; jmp_pc = 32'h1000 + 32'(i * 4); tick(); jmp_req = 1'b0;
      repeat (5) tick();
    end
    check("s7 saturated", cnt4, 32'hF);

    check("d1 events outstanding", q1.size(), 32'd0);
    check("d4 events outstanding", q4.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/redirect_flush_control.md
Name: redirect_flush_control

Overview:
- Squash-side companion to the pipeline stall controller. The stall controller holds stages on data hazards; this block kills wrong-path instructions on taken jumps and branches.
- Accepts a jump request resolved in ID and drives the fetch PC redirect (new_PC / ena_new_PC).
- Flushes the IF/ID and ID/EX pipeline registers for a parameterised number of slots.
- Sits between the ID-stage branch logic, the fetch unit and the pipeline-register enables.

Parameters:
- KILL_SLOTS, 1, cycles IF/ID flush stays asserted after the redirect cycle (1..7).
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- jmp_req_ID  input  1  ID stage has resolved a taken jump/branch this cycle.
- jmp_pc_ID  input  32  target address from ID.
- ena_ifid  input  1  enable from stall controller; 0 = ID is stalled.
- new_PC  output  32  redirect target for fetch.
- ena_new_PC  output  1  one-cycle load strobe for the fetch PC.
- flush_ifid  output  1  IF/ID register loads a NOP.
- flush_idex  output  1  ID/EX register loads a NOP.
- misaligned  output  1  one-cycle pulse: request had target[1:0] != 0.
- busy  output  1  high while not IDLE.
- redirect_count  output  CNT_W  number of accepted redirects, saturating.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; new_PC = 0, ena_new_PC = 0, flush_ifid = 0, flush_idex = 0, misaligned = 0, redirect_count = 0.
- Reset mid-REDIRECT/FLUSH aborts the operation. No strobe may follow in the cycle after rst deasserts.
- All outputs are registered.
- Acceptance: in IDLE, a request is accepted only when jmp_req_ID=1 and ena_ifid=1.
  - If ena_ifid=0, nothing happens. ID holds its instruction, so the request is re-presented and accepted on the first cycle ena_ifid=1.
- Aligned accept (jmp_pc_ID[1:0]==0) at edge N:
  - In cycle N+1: new_PC = jmp_pc_ID, ena_new_PC=1, flush_ifid=1, flush_idex=1; state = REDIRECT.
  - redirect_count increments; it holds at all-ones.
- Misaligned accept (jmp_pc_ID[1:0]!=0):
  - misaligned=1 for one cycle only.
  - No redirect, no flush, no count; state stays IDLE.
- REDIRECT (1 cycle): next state FLUSH with remaining = KILL_SLOTS.
  - In FLUSH cycles: ena_new_PC=0, flush_idex=0, flush_ifid=1.
- FLUSH: remaining decrements each cycle; on reaching 0 go to IDLE and deassert flush_ifid. Total flush_ifid width = 1 + KILL_SLOTS cycles.
- jmp_req_ID during REDIRECT/FLUSH is ignored: it is a wrong-path instruction being killed. This includes back-to-back requests on the cycle after accept.
- ena_ifid=0 during REDIRECT/FLUSH does not pause the sequence. A flush overrides a hold on the same register.
- new_PC holds its last value when ena_new_PC=0.
- busy = (state != IDLE).
- Target bits [1:0] are not modified on redirect; alignment is checked instead.

Decomposition:
- Shared package (riscv_ctrl_pkg):
  - State encoding: IDLE=2'd0, REDIRECT=2'd1, FLUSH=2'd2.
  - NOP instruction constant 32'h00000013, used by the pipeline registers on flush.
  - XLEN=32.
- One natural sub-module: sat_counter (CNT_W-wide saturating incrementer with synchronous clear), reusable for other performance counters.
- FSM and slot counter live in the top.

Test Plan:
- rst=1 for 2 cycles, then jmp_req_ID=1, jmp_pc_ID=32'h0000_0100, ena_ifid=1 → next cycle new_PC=0x100, ena_new_PC=1, flush_ifid=1, flush_idex=1; flush_ifid high exactly 2 cycles (KILL_SLOTS=1); redirect_count=1; busy high 2 cycles.
- Request 0x200 with ena_ifid=0 for 3 cycles, then 1 → no strobe while stalled; ena_new_PC pulses exactly once, in the cycle after ena_ifid rises.
- jmp_pc_ID=32'h0000_0102 → misaligned=1 for one cycle; ena_new_PC, flush_* stay 0; count unchanged.
- Requests on two consecutive cycles (0x300, then 0x400) → only 0x300 redirected; count +1; new_PC never shows 0x400.
- rst asserted during FLUSH (KILL_SLOTS=4) → next cycle all outputs 0, busy=0; a fresh request afterwards behaves as in scenario 1.
- CNT_W=4, 20 aligned redirects → redirect_count stops at 4'hF.
